// File: rtl/washer_plant_model.sv
// Plant model closing the loop around the washer controller: tank level, wash/spin timers, wash counter.
// Optional plant-fault detection is built when PLANT_FAULT_EN is defined; otherwise fault is tied to 0.
module washer_plant_model #(
    parameter int LEVEL_MAX   = 8,
    parameter int FILL_RATE   = 1,
    parameter int DRAIN_RATE  = 2,
    parameter int CYCLE_TICKS = 6,
    parameter int SPIN_TICKS  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       door_lock,
    input  logic       motor_on,
    input  logic       fill_val_on,
    input  logic       drain_val_on,
    input  logic       water_wash,
    input  logic       done,
    output logic       filled,
    output logic       drained,
    output logic       cycleTO,
    output logic       spinTO,
    output logic [7:0] level,
    output logic [3:0] wash_count,
    output logic       fault
);

    // state  | meaning
    // P_IDLE | no timed phase active
    // P_WASH | wash phase, cycle timer running
    // P_SPIN | pure spin phase, spin timer running
    typedef enum logic [1:0] {P_IDLE, P_WASH, P_SPIN} phase_t;

    localparam logic [7:0] LVL_MAX8 = 8'(LEVEL_MAX);
    localparam logic [8:0] LVL_MAX9 = 9'(LEVEL_MAX);
    localparam logic [8:0] FILL9    = 9'(FILL_RATE);
    localparam logic [8:0] DRAIN9   = 9'(DRAIN_RATE);
    localparam logic [7:0] CYC8     = 8'(CYCLE_TICKS);
    localparam logic [7:0] SPIN8    = 8'(SPIN_TICKS);

    phase_t     r_phase, w_phase_nxt;
    logic [7:0] r_level, w_level_nxt;
    logic [7:0] r_cycle_cnt, w_cycle_nxt;
    logic [7:0] r_spin_cnt, w_spin_nxt;
    logic [3:0] r_wash_count, w_wash_count_nxt;
    logic [8:0] w_lvl_up, w_lvl_dn;
    logic       w_wash_act, w_spin_act, w_wash_hit;

    // The motor pulse while still draining is the DRAIN->SPIN hand-off, not spinning.
    assign w_wash_act = water_wash;
    assign w_spin_act = motor_on & ~water_wash & ~drain_val_on;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_phase <= P_IDLE;
        else       r_phase <= w_phase_nxt;
    end

    always_comb begin
        w_phase_nxt = P_IDLE;
        if (w_wash_act)      w_phase_nxt = P_WASH;
        else if (w_spin_act) w_phase_nxt = P_SPIN;
    end

    assign w_lvl_up = {1'b0, r_level} + FILL9;
    assign w_lvl_dn = {1'b0, r_level} - DRAIN9;

    always_comb begin
        w_level_nxt = r_level;
        if (fill_val_on && !drain_val_on)
            w_level_nxt = (w_lvl_up > LVL_MAX9) ? LVL_MAX8 : w_lvl_up[7:0];
        else if (drain_val_on && !fill_val_on)
            w_level_nxt = w_lvl_dn[8] ? 8'd0 : w_lvl_dn[7:0];
    end

    // Counters run only while staying in their phase; entry or exit clears them.
    always_comb begin
        w_cycle_nxt = 8'd0;
        w_spin_nxt  = 8'd0;
        w_wash_hit  = 1'b0;
        if (r_phase == P_WASH && w_wash_act) begin
            w_cycle_nxt = (r_cycle_cnt == CYC8) ? r_cycle_cnt : r_cycle_cnt + 8'd1;
            w_wash_hit  = (r_cycle_cnt != CYC8) && (w_cycle_nxt == CYC8);
        end
        if (r_phase == P_SPIN && w_spin_act)
            w_spin_nxt = (r_spin_cnt == SPIN8) ? r_spin_cnt : r_spin_cnt + 8'd1;
    end

    always_comb begin
        w_wash_count_nxt = r_wash_count;
        if (done)
            w_wash_count_nxt = 4'd0;
        else if (w_wash_hit && r_wash_count != 4'd15)
            w_wash_count_nxt = r_wash_count + 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level      <= 8'd0;
            r_cycle_cnt  <= 8'd0;
            r_spin_cnt   <= 8'd0;
            r_wash_count <= 4'd0;
        end else begin
            r_level      <= w_level_nxt;
            r_cycle_cnt  <= w_cycle_nxt;
            r_spin_cnt   <= w_spin_nxt;
            r_wash_count <= w_wash_count_nxt;
        end
    end

    assign level      = r_level;
    assign wash_count = r_wash_count;
    assign filled     = (r_level == LVL_MAX8);
    assign drained    = (r_level == 8'd0);
    assign cycleTO    = (r_phase == P_WASH) && (r_cycle_cnt == CYC8);
    assign spinTO     = (r_phase == P_SPIN) && (r_spin_cnt == SPIN8);

`ifdef PLANT_FAULT_EN
    logic r_fault, r_full_fill;
    logic w_full_fill, w_fault_cond;

    // Overflow needs the fill valve open on a full tank for two edges in a row.
    assign w_full_fill  = fill_val_on && (r_level == LVL_MAX8);
    assign w_fault_cond = (fill_val_on & drain_val_on)
                        | (fill_val_on & ~door_lock)
                        | (w_spin_act & (r_level != 8'd0))
                        | (w_full_fill & r_full_fill);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fault     <= 1'b0;
            r_full_fill <= 1'b0;
        end else begin
            r_fault     <= r_fault | w_fault_cond;
            r_full_fill <= w_full_fill;
        end
    end

    assign fault = r_fault;
`else
    logic w_unused_door_lock;
    assign w_unused_door_lock = door_lock;
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_washer_plant_model.sv
// Bench for washer_plant_model: directed test-plan sequences plus randomized command segments,
// checked against an event-count reference model on two parameterisations (LEVEL_MAX 8 and 7).
module tb_washer_plant_model;

    localparam int CT = 6;
    localparam int ST = 4;
    localparam int FR = 1;
    localparam int DR = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic door_lock = 1'b0, motor_on = 1'b0, fill_val_on = 1'b0;
    logic drain_val_on = 1'b0, water_wash = 1'b0, done = 1'b0;

    logic       filled8, drained8, cto8, sto8, fault8;
    logic [7:0] level8;
    logic [3:0] wc8;
    logic       filled7, drained7, cto7, sto7, fault7;
    logic [7:0] level7;
    logic [3:0] wc7;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: level plus run lengths of consecutive wash / pure-spin edges.
    int lmax[2] = '{8, 7};
    int m_level[2], m_wrun[2], m_srun[2], m_wcnt[2];
    bit m_fault[2], m_fullfill[2];

    always #5 clk = ~clk;

    washer_plant_model u_dut8 (
        .clk(clk), .reset(reset), .door_lock(door_lock), .motor_on(motor_on),
        .fill_val_on(fill_val_on), .drain_val_on(drain_val_on), .water_wash(water_wash), .done(done),
        .filled(filled8), .drained(drained8), .cycleTO(cto8), .spinTO(sto8),
        .level(level8), .wash_count(wc8), .fault(fault8)
    );

    washer_plant_model #(.LEVEL_MAX(7)) u_dut7 (
        .clk(clk), .reset(reset), .door_lock(door_lock), .motor_on(motor_on),
        .fill_val_on(fill_val_on), .drain_val_on(drain_val_on), .water_wash(water_wash), .done(done),
        .filled(filled7), .drained(drained7), .cycleTO(cto7), .spinTO(sto7),
        .level(level7), .wash_count(wc7), .fault(fault7)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_cmp++;
        if (obs !== 32'(exp)) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_level[k] = 0; m_wrun[k] = 0; m_srun[k] = 0; m_wcnt[k] = 0;
            m_fault[k] = 1'b0; m_fullfill[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit wa, sa, ff;
        wa = water_wash;
        sa = motor_on && !water_wash && !drain_val_on;
        for (int k = 0; k < 2; k++) begin
`ifdef PLANT_FAULT_EN
            ff = fill_val_on && (m_level[k] == lmax[k]);
            if ((fill_val_on && drain_val_on) || (fill_val_on && !door_lock) ||
                (sa && m_level[k] != 0) || (ff && m_fullfill[k]))
                m_fault[k] = 1'b1;
            m_fullfill[k] = ff;
`else
            ff = 1'b0;
`endif
            if (fill_val_on && !drain_val_on)
                m_level[k] = (m_level[k] + FR > lmax[k]) ? lmax[k] : m_level[k] + FR;
            else if (drain_val_on && !fill_val_on)
                m_level[k] = (m_level[k] - DR < 0) ? 0 : m_level[k] - DR;
            m_wrun[k] = wa ? ((m_wrun[k] < 1000) ? m_wrun[k] + 1 : 1000) : 0;
            m_srun[k] = sa ? ((m_srun[k] < 1000) ? m_srun[k] + 1 : 1000) : 0;
            if (m_wrun[k] == CT + 1 && m_wcnt[k] < 15) m_wcnt[k]++;
            if (done) m_wcnt[k] = 0;
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            string p;
            p = $sformatf("L%0d_", lmax[k]);
            chk({p, "level"},   (k == 0) ? 32'(level8) : 32'(level7), m_level[k]);
            chk({p, "filled"},  (k == 0) ? 32'(filled8) : 32'(filled7), int'(m_level[k] == lmax[k]));
            chk({p, "drained"}, (k == 0) ? 32'(drained8) : 32'(drained7), int'(m_level[k] == 0));
            chk({p, "cycleTO"}, (k == 0) ? 32'(cto8) : 32'(cto7), int'(m_wrun[k] > CT));
            chk({p, "spinTO"},  (k == 0) ? 32'(sto8) : 32'(sto7), int'(m_srun[k] > ST));
            chk({p, "wash_count"}, (k == 0) ? 32'(wc8) : 32'(wc7), m_wcnt[k]);
            chk({p, "fault"},   (k == 0) ? 32'(fault8) : 32'(fault7), int'(m_fault[k]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // Called just after a check (posedge+1): asserts reset between edges, releases before the next.
    task automatic async_reset();
        #3 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("rst_drained", 32'(drained8), 1);
        chk("rst_cycleTO", 32'(cto8), 0);
        #2 reset = 1'b0;
    endtask

    task automatic set_cmd(input logic dl, input logic mo, input logic fv, input logic dv,
                           input logic ww, input logic dn);
        door_lock = dl; motor_on = mo; fill_val_on = fv;
        drain_val_on = dv; water_wash = ww; done = dn;
    endtask

    initial begin
        int exp_drain7[5] = '{5, 3, 1, 0, 0};

        reset = 1'b1;
        model_reset();
        #2;
        compare_all();
        chk("rst_level", 32'(level8), 0);
        @(negedge clk);
        reset = 1'b0;

        // Fill to full and beyond: clamp at LEVEL_MAX.
        set_cmd(1, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            cycle();
            chk("fill_level8", 32'(level8), (i < 8) ? i : 8);
            chk("fill_filled8", 32'(filled8), int'(i >= 8));
        end

        // Drain with clamp at 0 on the LEVEL_MAX=7 instance.
        set_cmd(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("drain_level7", 32'(level7), exp_drain7[i]);
        end
        chk("drain_drained7", 32'(drained7), 1);

        // Wash timer: entry edge plus CT counting edges.
        async_reset();
        set_cmd(1, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 9; i++) begin
            cycle();
            chk("wash_cto", 32'(cto8), int'(i >= CT + 1));
        end
        chk("wash_count1", 32'(wc8), 1);
        set_cmd(1, 0, 0, 0, 0, 0);
        cycle();
        chk("wash_cto_drop", 32'(cto8), 0);
        set_cmd(1, 0, 0, 0, 1, 0);
        repeat (CT + 2) cycle();
        chk("wash_count2", 32'(wc8), 2);
        set_cmd(1, 0, 0, 0, 0, 1);
        cycle();
        chk("done_clear", 32'(wc8), 0);

        // Spin gating: motor with drain open is not spin.
        set_cmd(1, 1, 0, 1, 0, 0);
        cycle();
        chk("spin_gated", 32'(sto8), 0);
        set_cmd(1, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            cycle();
            chk("spin_sto", 32'(sto8), int'(i >= ST + 1));
        end

        // Reset mid-wash with a full tank and cycle_cnt at 3.
        set_cmd(1, 0, 1, 0, 0, 0);
        repeat (8) cycle();
        set_cmd(1, 0, 0, 0, 1, 0);
        repeat (4) cycle();
        chk("midwash_level", 32'(level8), 8);
        async_reset();
        chk("midwash_rst_level", 32'(level8), 0);
        chk("midwash_rst_wc", 32'(wc8), 0);
        repeat (CT + 2) cycle();
        chk("midwash_resume_cto", 32'(cto8), 1);

        // Fault: fill with door unlocked for one clock.
        async_reset();
        set_cmd(0, 0, 1, 0, 0, 0);
        cycle();
        set_cmd(0, 0, 0, 0, 0, 0);
        repeat (3) cycle();
`ifdef PLANT_FAULT_EN
        chk("fault_sticky", 32'(fault8), 1);
`else
        chk("fault_absent", 32'(fault8), 0);
`endif

        // Randomized command segments.
        for (int s = 0; s < 300; s++) begin
            int pat, len;
            pat = $urandom_range(0, 5);
            len = $urandom_range(1, 12);
            case (pat)
                0: set_cmd(1, 0, 0, 0, 0, 0);
                1: set_cmd(1, 0, 1, 0, 0, 0);
                2: set_cmd(1, 1'($urandom_range(0, 1)), 0, 1, 0, 0);
                3: set_cmd(1, 1'($urandom_range(0, 1)), 0, 0, 1, 0);
                4: set_cmd(1, 1, 0, 0, 0, 0);
                default: set_cmd(1'($urandom), 1'($urandom), 1'($urandom),
                                 1'($urandom), 1'($urandom), 0);
            endcase
            for (int c = 0; c < len; c++) begin
                done = ($urandom_range(0, 15) == 0);
                cycle();
            end
            if ($urandom_range(0, 39) == 0) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/washer_plant_model.md
Name: washer_plant_model

Overview:
- Behavioural plant model for the washing-machine controller: it consumes the controller's actuator commands and generates the sensor and timer responses the controller waits on (`filled`, `drained`, `cycleTO`, `spinTO`).
- Models water level, wash-cycle timer, spin timer and a completed-wash counter.
- Closes the loop in system benches and FPGA demo builds; it is the opposite end of the controller's sensor/actuator interface.

Parameters:
- LEVEL_MAX, 8, full-tank level. Range 1..255.
- FILL_RATE, 1, level increment per clock while filling. Range 1..LEVEL_MAX.
- DRAIN_RATE, 2, level decrement per clock while draining. Range 1..LEVEL_MAX.
- CYCLE_TICKS, 6, consecutive wash clocks before `cycleTO`. Range 1..255.
- SPIN_TICKS, 4, consecutive spin clocks before `spinTO`. Range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- door_lock  input  1  controller door-lock command.
- motor_on  input  1  controller motor command.
- fill_val_on  input  1  controller fill-valve command.
- drain_val_on  input  1  controller drain-valve command.
- water_wash  input  1  controller wash-phase indicator.
- done  input  1  controller programme-complete pulse.
- filled  output  1  tank full, i.e. level == LEVEL_MAX.
- drained  output  1  tank empty, i.e. level == 0.
- cycleTO  output  1  wash timer expired.
- spinTO  output  1  spin timer expired.
- level  output  8  current water level.
- wash_count  output  4  completed wash cycles in the current programme.
- fault  output  1  sticky plant-fault flag.

Behaviour:
- Interface: one clock domain, `clk`. `reset` is asynchronous and active-high. All state registers clear immediately on `reset`.
- Reset values: level=0, cycle_cnt=0, spin_cnt=0, wash_count=0, fault=0. Hence after reset: drained=1, filled=0, cycleTO=0, spinTO=0.
- Reset mid-operation: everything returns to the reset values at once; the tank is modelled as emptied.
- Output timing: `filled`, `drained`, `cycleTO` and `spinTO` are decoded combinationally from registered state. A register change is visible in the same cycle it is updated, one clock after the causing command.
- Level update, per rising edge:
  - fill_val_on=1, drain_val_on=0: level = min(level+FILL_RATE, LEVEL_MAX).
  - drain_val_on=1, fill_val_on=0: level = max(level−DRAIN_RATE, 0).
  - Both asserted or both deasserted: level holds.
  - Arithmetic is done at 9 bits and then clamped, so there is no wrap at either bound.
- Phase decode (combinational):
  - wash_act = water_wash.
  - spin_act = motor_on & ~water_wash & ~drain_val_on. This excludes the single transitional DRAIN→SPIN motor pulse.
- Phase FSM states: P_IDLE, P_WASH, P_SPIN.
  - Next state is P_WASH if wash_act, else P_SPIN if spin_act, else P_IDLE.
  - Entering or leaving a phase clears that phase's counter on the same edge.
- Wash timer:
  - In P_WASH with wash_act=1, cycle_cnt increments and saturates at CYCLE_TICKS.
  - cycleTO = (cycle_cnt == CYCLE_TICKS). It stays high until water_wash drops.
  - Result: with water_wash held from edge 0, cycleTO rises after edge CYCLE_TICKS+1 (one clock for phase entry, then CYCLE_TICKS counts).
  - wash_count increments, saturating at 15, on the edge where cycle_cnt reaches CYCLE_TICKS.
- Spin timer: identical to the wash timer but uses spin_act, spin_cnt, SPIN_TICKS and spinTO. Spin does not touch wash_count.
- Done handling: `done`=1 at an edge clears wash_count to 0. If `done` coincides with a wash_count increment, the clear wins.
- Simultaneous wash_act and spin_act: impossible by the decode; wash has priority.
- Both phase-timer outputs are forced to 0 outside their own phase. A stale timeout never reaches the controller on phase entry.

Optional Feature:
- Macro: PLANT_FAULT_EN.
- When defined, `fault` sets at an edge, and stays set until `reset`, if any of the following holds:
  - fill_val_on & drain_val_on;
  - fill_val_on & ~door_lock;
  - spin_act & (level != 0), i.e. spinning with water in the tank;
  - fill_val_on while level == LEVEL_MAX for 2 or more consecutive clocks, i.e. overflow.
- When not defined: `fault` is tied to 0 and the detection logic is absent. All other behaviour is identical.

Test Plan:
- Fill: reset, then door_lock=1, fill_val_on=1 held → level 1,2,…,8 on successive edges; filled=1 after edge 8; level holds at 8 thereafter.
- Drain with clamp: LEVEL_MAX=7, DRAIN_RATE=2, start from level 7, drain_val_on=1 → level 5,3,1,0; drained=1 after edge 4; no wrap to 255.
- Wash timer: water_wash=1 held → cycleTO=0 through edge 6, cycleTO=1 after edge 7, wash_count=1. Drop water_wash → cycleTO=0 next cycle. A second wash → wash_count=2. A `done` pulse → wash_count=0.
- Spin gating: motor_on=1, drain_val_on=1 for one clock, then drain_val_on=0 → spin counting starts only after drain_val_on drops; spinTO=1 after 5 edges of pure spin.
- Reset mid-wash: with level=8 and cycle_cnt=3, assert reset asynchronously between edges → level=0, drained=1, cycleTO=0, wash_count=0 immediately; normal operation resumes on the first edge after release.
- Fault (PLANT_FAULT_EN defined): fill_val_on=1 with door_lock=0 for one clock → fault=1 and remains 1 after commands return to idle. Same stimulus with the macro undefined → fault stays 0.
